// File: rtl/fill_if.sv
// Command and pixel-stream bundle between a fill requester and fill_engine.
// The requester (master) drives the command; the engine (slave) drives the pixel stream.
interface fill_if #(
    parameter int H_RES   = 160,
    parameter int V_RES   = 120,
    parameter int COLOR_W = 3
);
    localparam int X_W = $clog2(H_RES);
    localparam int Y_W = $clog2(V_RES);

    logic               start;
    logic               abort;
    logic [1:0]         mode;
    logic [COLOR_W-1:0] color_a;
    logic [COLOR_W-1:0] color_b;
    logic [X_W-1:0]     x0;
    logic [X_W-1:0]     x1;
    logic [Y_W-1:0]     y0;
    logic [Y_W-1:0]     y1;

    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
    logic               plot;
    logic               busy;
    logic               done;

    modport master (
        output start, abort, mode, color_a, color_b, x0, x1, y0, y1,
        input  x, y, color, plot, busy, done
    );

    modport slave (
        input  start, abort, mode, color_a, color_b, x0, x1, y0, y1,
        output x, y, color, plot, busy, done
    );
endinterface

// File: rtl/fill_engine.sv
// Raster fill engine: emits one clipped pixel per clock over a rectangle, in solid
// or checkerboard colour, with start/busy/done handshake and abort.
module fill_engine #(
    parameter int H_RES     = 160,
    parameter int V_RES     = 120,
    parameter int COLOR_W   = 3,
    parameter int CHK_SHIFT = 3
) (
    input logic   clk,
    input logic   reset_n,
    fill_if.slave bus
);
    localparam int X_W = $clog2(H_RES);
    localparam int Y_W = $clog2(V_RES);
    localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t             state, state_n;
    logic [X_W-1:0]     x_q, x_n, xs_q, xs_n, xe_q, xe_n;
    logic [Y_W-1:0]     y_q, y_n, ye_q, ye_n;
    logic               chk_q, chk_n;
    logic [COLOR_W-1:0] ca_q, ca_n, cb_q, cb_n, color_q, color_n;
    logic               plot_q, plot_n, busy_q, busy_n, done_q, done_n;

    logic [X_W-1:0]     clip_xe;
    logic [Y_W-1:0]     clip_ye;
    logic               empty;

    function automatic logic [COLOR_W-1:0] pix_color(
        input logic               chk,
        input logic [X_W-1:0]     px,
        input logic [Y_W-1:0]     py,
        input logic [COLOR_W-1:0] ca,
        input logic [COLOR_W-1:0] cb
    );
        return (chk && (px[CHK_SHIFT] ^ py[CHK_SHIFT])) ? cb : ca;
    endfunction

    assign clip_xe = (bus.x1 > X_MAX) ? X_MAX : bus.x1;
    assign clip_ye = (bus.y1 > Y_MAX) ? Y_MAX : bus.y1;
    // An origin beyond the screen is already caught by the clipped compare; kept explicit for clarity.
    assign empty   = (bus.x0 > clip_xe) || (bus.y0 > clip_ye) ||
                     ({1'b0, bus.x0} >= (X_W+1)'(H_RES)) ||
                     ({1'b0, bus.y0} >= (Y_W+1)'(V_RES));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_n = state;
        x_n     = x_q;
        y_n     = y_q;
        xs_n    = xs_q;
        xe_n    = xe_q;
        ye_n    = ye_q;
        chk_n   = chk_q;
        ca_n    = ca_q;
        cb_n    = cb_q;
        color_n = color_q;
        plot_n  = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    xs_n  = bus.x0;
                    xe_n  = clip_xe;
                    ye_n  = clip_ye;
                    chk_n = (bus.mode == 2'd1);
                    ca_n  = bus.color_a;
                    cb_n  = bus.color_b;
                    if (empty) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = FILL;
                        x_n     = bus.x0;
                        y_n     = bus.y0;
                        plot_n  = 1'b1;
                        busy_n  = 1'b1;
                        color_n = pix_color(bus.mode == 2'd1, bus.x0, bus.y0,
                                            bus.color_a, bus.color_b);
                    end
                end
            end
            FILL: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (x_q == xe_q && y_q == ye_q) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    plot_n = 1'b1;
                    busy_n = 1'b1;
                    if (x_q == xe_q) begin
                        x_n = xs_q;
                        y_n = y_q + Y_W'(1);
                    end else begin
                        x_n = x_q + X_W'(1);
                    end
                    color_n = pix_color(chk_q, x_n, y_n, ca_q, cb_q);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            xs_q    <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            chk_q   <= 1'b0;
            ca_q    <= '0;
            cb_q    <= '0;
            color_q <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            x_q     <= x_n;
            y_q     <= y_n;
            xs_q    <= xs_n;
            xe_q    <= xe_n;
            ye_q    <= ye_n;
            chk_q   <= chk_n;
            ca_q    <= ca_n;
            cb_q    <= cb_n;
            color_q <= color_n;
            plot_q  <= plot_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign bus.x     = x_q;
    assign bus.y     = y_q;
    assign bus.color = color_q;
    assign bus.plot  = plot_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_fill_engine.sv
// Directed bench for fill_engine: solid, checkerboard, clipping, empty region,
// abort, start-while-busy and asynchronous reset.
module tb_fill_engine;
    localparam int H_RES     = 160;
    localparam int V_RES     = 120;
    localparam int COLOR_W   = 3;
    localparam int CHK_SHIFT = 3;
    localparam int X_W       = $clog2(H_RES);
    localparam int Y_W       = $clog2(V_RES);

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    always #5 clk = ~clk;

    fill_if #(.H_RES(H_RES), .V_RES(V_RES), .COLOR_W(COLOR_W)) bus ();

    fill_engine #(
        .H_RES(H_RES), .V_RES(V_RES), .COLOR_W(COLOR_W), .CHK_SHIFT(CHK_SHIFT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_color(input int md, input int px, input int py,
                                       input int ca, input int cb);
        if (md == 1 && (((px >> CHK_SHIFT) ^ (py >> CHK_SHIFT)) & 1) == 1) return cb;
        return ca;
    endfunction

    // Called at a falling edge; returns at the falling edge of cycle 1.
    task automatic do_start(input int x0, input int x1, input int y0, input int y1,
                            input int md, input int ca, input int cb);
        bus.x0      = X_W'(x0);
        bus.x1      = X_W'(x1);
        bus.y0      = Y_W'(y0);
        bus.y1      = Y_W'(y1);
        bus.mode    = 2'(md);
        bus.color_a = COLOR_W'(ca);
        bus.color_b = COLOR_W'(cb);
        bus.start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    // Walks the expected raster; returns at the falling edge of cycle N+2.
    task automatic expect_fill(input string tag, input int xs, input int xe,
                               input int ys, input int ye, input int md,
                               input int ca, input int cb);
        int errs = 0;
        for (int yy = ys; yy <= ye; yy++) begin
            for (int xx = xs; xx <= xe; xx++) begin
                if (bus.plot !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
                    bus.x !== X_W'(xx) || bus.y !== Y_W'(yy) ||
                    bus.color !== COLOR_W'(model_color(md, xx, yy, ca, cb)))
                    errs++;
                @(negedge clk);
            end
        end
        check({tag, "_pixels"}, errs, 0);
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_plot_end"}, bus.plot, 0);
        check({tag, "_busy_end"}, bus.busy, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int errs;
        bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 2'd0;
        bus.color_a = '0; bus.color_b = '0;
        bus.x0 = '0; bus.x1 = '0; bus.y0 = '0; bus.y1 = '0;

        #1 reset_n = 1'b0;
        #2;
        check("rst_plot", bus.plot, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_x", bus.x, 0);
        check("rst_y", bus.y, 0);
        check("rst_color", bus.color, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Full-screen solid fill, colour 5, 19200 pixels.
        do_start(0, 159, 0, 119, 0, 5, 0);
        expect_fill("full", 0, 159, 0, 119, 0, 5, 0);

        // Checkerboard rectangle: row 7 is 1,1,6,6; row 8 is 6,6,1,1.
        do_start(6, 9, 7, 8, 1, 1, 6);
        check("chk_first_color", bus.color, 1);
        expect_fill("chk", 6, 9, 7, 8, 1, 1, 6);

        // Right edge clipped to 159; reserved mode 2 behaves as solid.
        do_start(150, 200, 119, 119, 2, 3, 7);
        expect_fill("clip", 150, 159, 119, 119, 2, 3, 7);

        // Empty region: done in cycle 1, no plot, x/y hold last pixel.
        do_start(5, 4, 0, 0, 0, 1, 1);
        check("empty_done", bus.done, 1);
        check("empty_plot", bus.plot, 0);
        check("empty_busy", bus.busy, 0);
        check("empty_x_hold", bus.x, 159);
        check("empty_y_hold", bus.y, 119);
        @(negedge clk);
        check("empty_done_pulse", bus.done, 0);
        check("empty_plot2", bus.plot, 0);

        // Abort in cycle 50 of a full-screen fill.
        do_start(0, 159, 0, 119, 0, 6, 0);
        errs = 0;
        for (int k = 1; k <= 50; k++) begin
            if (bus.plot !== 1'b1 || bus.x !== X_W'(k - 1) || bus.color !== 3'd6) errs++;
            if (k < 50) @(negedge clk);
        end
        check("abort_pre_pixels", errs, 0);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_plot", bus.plot, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_x_hold", bus.x, 49);
        @(negedge clk);
        check("abort_no_done", bus.done, 0);
        do_start(0, 3, 0, 0, 0, 4, 0);
        expect_fill("restart", 0, 3, 0, 0, 0, 4, 0);

        // Start while busy (cycle 10, new colour) then reset in cycle 100.
        do_start(0, 159, 0, 119, 0, 5, 0);
        errs = 0;
        for (int k = 1; k <= 99; k++) begin
            if (bus.plot !== 1'b1 || bus.busy !== 1'b1 || bus.x !== X_W'(k - 1) ||
                bus.y !== Y_W'(0) || bus.color !== 3'd5)
                errs++;
            if (k == 10) begin
                bus.start   = 1'b1;
                bus.color_a = 3'd2;
                bus.x0      = X_W'(20);
            end
            if (k == 11) bus.start = 1'b0;
            @(negedge clk);
        end
        check("busy_start_ignored", errs, 0);
        reset_n = 1'b0;
        #1;
        check("areset_plot", bus.plot, 0);
        check("areset_busy", bus.busy, 0);
        check("areset_done", bus.done, 0);
        check("areset_x", bus.x, 0);
        check("areset_y", bus.y, 0);
        check("areset_color", bus.color, 0);
        @(negedge clk);
        reset_n = 1'b1;
        errs = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.plot !== 1'b0) errs++;
        end
        check("post_reset_idle", errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
